// File: rtl/reg_file_mp_if.sv
// Register-file port bundle: N_RD packed combinational read ports, one write port, clear control.
// The master side drives addresses/write/clear requests; the slave returns read data and clear status.
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_RD   = 2
);
    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD*DATA_W-1:0] rd_data;
    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wd;
    logic                   clr_req;
    logic                   clr_busy;
    logic                   clr_done;

    modport master (
        output rd_addr, we, waddr, wd, clr_req,
        input  rd_data, clr_busy, clr_done
    );

    modport slave (
        input  rd_addr, we, waddr, wd, clr_req,
        output rd_data, clr_busy, clr_done
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with write-through bypass, optional hardwired x0 and a bulk-clear engine.
// Reads are combinational (zero latency); a clear sweeps one entry per cycle and drops writes while busy.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              busy;
    logic              zero_waddr;
    logic              wr_en;

    assign busy       = (state != IDLE);
    assign zero_waddr = ZERO_REG && (bus.waddr == '0);
    assign wr_en      = bus.we && (state == IDLE) && !zero_waddr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt parks at DEPTH-1 on the final clear cycle instead of wrapping
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == ADDR_W'(DEPTH-1)) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            mem[bus.waddr] <= bus.wd;
        end
    end

    assign bus.clr_busy = busy;
    assign bus.clr_done = (state == DONE);

    // Bypass is disabled while the clear engine owns the array, matching the dropped write
    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;

        assign ra  = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign hit = bus.we && !busy && (bus.waddr == ra) && !zero_waddr;
        assign bus.rd_data[k*DATA_W +: DATA_W] = (ZERO_REG && (ra == '0)) ? '0 :
                                                 hit                      ? bus.wd :
                                                                            mem[ra];
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: default 32x32/2-port with x0, a no-x0 twin, and an 8x16/4-port variant.
module tb_reg_file_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .N_RD(2)) b0 ();
    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .N_RD(2)) b1 ();
    reg_file_mp_if #(.DATA_W(16), .ADDR_W(3), .N_RD(4)) b2 ();

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1'b1)) u_z (
        .clk(clk), .rst(rst), .bus(b0.slave));
    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1'b0)) u_nz (
        .clk(clk), .rst(rst), .bus(b1.slave));
    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .N_RD(4), .ZERO_REG(1'b1)) u_w (
        .clk(clk), .rst(rst), .bus(b2.slave));

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] sb [$];
    logic [31:0] exp_v;
    logic [31:0] got_v;

    task automatic idle_inputs();
        b0.we = 1'b0; b0.waddr = '0; b0.wd = '0; b0.rd_addr = '0; b0.clr_req = 1'b0;
        b1.we = 1'b0; b1.waddr = '0; b1.wd = '0; b1.rd_addr = '0; b1.clr_req = 1'b0;
        b2.we = 1'b0; b2.waddr = '0; b2.wd = '0; b2.rd_addr = '0; b2.clr_req = 1'b0;
    endtask

    task automatic fill_b0();
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            b0.we = 1'b1; b0.waddr = 5'(a); b0.wd = 32'(a);
        end
        @(negedge clk);
        b0.we = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd0);
        for (int i = 0; i < 3; i++) begin
            got_v = (i == 0) ? 32'(b0.clr_busy) : (i == 1) ? 32'(b0.clr_done) : 32'(b2.clr_busy);
            exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL reset_status idx%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            b0.rd_addr = {5'(31 - a), 5'(a)};
            sb.push_back(32'd0); sb.push_back(32'd0);
            #2;
            for (int p = 0; p < 2; p++) begin
                got_v = b0.rd_data[p*32 +: 32]; exp_v = sb.pop_front(); vectors++;
                if (got_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL reset_read a=%0d port%0d got=%h exp=%h", a, p, got_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        b0.we = 1'b1; b0.waddr = 5'd5; b0.wd = 32'hDEADBEEF; b0.rd_addr = {5'd1, 5'd1};
        @(negedge clk);
        b0.we = 1'b0; b0.rd_addr = {5'd5, 5'd5};
        sb.push_back(32'hDEADBEEF); sb.push_back(32'hDEADBEEF);
        #2;
        for (int p = 0; p < 2; p++) begin
            got_v = b0.rd_data[p*32 +: 32]; exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL write_read port%0d got=%h exp=%h", p, got_v, exp_v);
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        b0.we = 1'b1; b0.waddr = 5'd8; b0.wd = 32'h88888888; b0.rd_addr = '0;
        for (int step = 0; step < 3; step++) begin
            @(negedge clk);
            case (step)
                0: begin
                    b0.waddr = 5'd7; b0.wd = 32'h12345678; b0.rd_addr = {5'd8, 5'd7};
                    sb.push_back(32'h12345678); sb.push_back(32'h88888888);
                end
                1: begin
                    b0.waddr = 5'd9; b0.wd = 32'h99999999; b0.rd_addr = {5'd9, 5'd9};
                    sb.push_back(32'h99999999); sb.push_back(32'h99999999);
                end
                default: begin
                    b0.we = 1'b0; b0.rd_addr = {5'd7, 5'd9};
                    sb.push_back(32'h99999999); sb.push_back(32'h12345678);
                end
            endcase
            #2;
            for (int p = 0; p < 2; p++) begin
                got_v = b0.rd_data[p*32 +: 32]; exp_v = sb.pop_front(); vectors++;
                if (got_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL bypass step%0d port%0d got=%h exp=%h", step, p, got_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_zero_reg();
        for (int step = 0; step < 2; step++) begin
            @(negedge clk);
            b0.we = (step == 0); b0.waddr = 5'd0; b0.wd = 32'hFFFFFFFF; b0.rd_addr = '0;
            b1.we = (step == 0); b1.waddr = 5'd0; b1.wd = 32'hFFFFFFFF; b1.rd_addr = '0;
            sb.push_back(32'd0); sb.push_back(32'd0);
            sb.push_back(32'hFFFFFFFF); sb.push_back(32'hFFFFFFFF);
            #2;
            for (int i = 0; i < 4; i++) begin
                got_v = (i < 2) ? b0.rd_data[i*32 +: 32] : b1.rd_data[(i-2)*32 +: 32];
                exp_v = sb.pop_front(); vectors++;
                if (got_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL zero_reg step%0d idx%0d got=%h exp=%h", step, i, got_v, exp_v);
                end
            end
        end
        b0.we = 1'b0; b1.we = 1'b0;
    endtask

    task automatic test_clear();
        int busy_n = 0;
        int done_n = 0;
        int done_at = -1;
        fill_b0();
        @(negedge clk);
        b0.clr_req = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            #2;
            if (b0.clr_busy) busy_n++;
            if (b0.clr_done) begin done_n++; done_at = j; end
            b0.clr_req = (j == 5);
            b0.we = 1'b0;
            if (j == 0 || j == 10 || j == 21) begin
                if (j == 0) begin
                    b0.we = 1'b1; b0.waddr = 5'd3; b0.wd = 32'hAA; b0.rd_addr = {5'd3, 5'd3};
                    sb.push_back(32'd3); sb.push_back(32'd3);
                end else if (j == 10) begin
                    b0.rd_addr = {5'd20, 5'd9};
                    sb.push_back(32'd0); sb.push_back(32'd20);
                end else begin
                    b0.we = 1'b1; b0.waddr = 5'd2; b0.wd = 32'hAA; b0.rd_addr = {5'd2, 5'd2};
                    sb.push_back(32'd0); sb.push_back(32'd0);
                end
                #1;
                for (int p = 0; p < 2; p++) begin
                    got_v = b0.rd_data[p*32 +: 32]; exp_v = sb.pop_front(); vectors++;
                    if (got_v !== exp_v) begin
                        miscompares++;
                        $display("FAIL clear_read j=%0d port%0d got=%h exp=%h", j, p, got_v, exp_v);
                    end
                end
            end
            if (j == 20 || j == 32) begin
                b0.we = 1'b1; b0.waddr = (j == 20) ? 5'd2 : 5'd4; b0.wd = 32'hAA;
            end
        end
        sb.push_back(32'd33); sb.push_back(32'd1); sb.push_back(32'd32);
        for (int i = 0; i < 3; i++) begin
            got_v = (i == 0) ? 32'(busy_n) : (i == 1) ? 32'(done_n) : 32'(done_at);
            exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL clear_timing idx%0d got=%0d exp=%0d", i, got_v, exp_v);
            end
        end
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            b0.rd_addr = {5'(a), 5'(a)};
            sb.push_back(32'd0);
            #2;
            got_v = b0.rd_data[31:0]; exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL clear_final a=%0d got=%h exp=%h", a, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int done_n = 0;
        int busy_n = 0;
        fill_b0();
        @(negedge clk);
        b0.clr_req = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            b0.clr_req = 1'b0;
        end
        #2;
        b0.rd_addr = {5'd31, 5'd20};
        sb.push_back(32'd20); sb.push_back(32'd31);
        #1;
        for (int p = 0; p < 2; p++) begin
            got_v = b0.rd_data[p*32 +: 32]; exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL midclear_pre port%0d got=%h exp=%h", p, got_v, exp_v);
            end
        end
        rst = 1'b0;
        sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd0);
        #1;
        for (int i = 0; i < 4; i++) begin
            got_v = (i < 2) ? b0.rd_data[i*32 +: 32] : (i == 2) ? 32'(b0.clr_busy) : 32'(b0.clr_done);
            exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL midclear_async idx%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            #2;
            if (b0.clr_done) done_n++;
            if (b0.clr_busy) busy_n++;
        end
        sb.push_back(32'd0); sb.push_back(32'd0);
        for (int i = 0; i < 2; i++) begin
            got_v = (i == 0) ? 32'(done_n) : 32'(busy_n);
            exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL midclear_after idx%0d got=%0d exp=%0d", i, got_v, exp_v);
            end
        end
        @(negedge clk);
        b0.we = 1'b1; b0.waddr = 5'd2; b0.wd = 32'h55; b0.rd_addr = {5'd20, 5'd20};
        @(negedge clk);
        b0.we = 1'b0; b0.rd_addr = {5'd20, 5'd2};
        sb.push_back(32'h55); sb.push_back(32'd0);
        #2;
        for (int p = 0; p < 2; p++) begin
            got_v = b0.rd_data[p*32 +: 32]; exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL midclear_write port%0d got=%h exp=%h", p, got_v, exp_v);
            end
        end
    endtask

    task automatic test_wide();
        int clr_n = 0;
        int done_n = 0;
        for (int a = 1; a <= 4; a++) begin
            @(negedge clk);
            b2.we = 1'b1; b2.waddr = 3'(a); b2.wd = 16'(a * 16'h1111);
        end
        for (int step = 0; step < 2; step++) begin
            @(negedge clk);
            b2.we = (step == 0); b2.waddr = 3'd3; b2.wd = 16'hBEEF;
            b2.rd_addr = {3'd4, 3'd3, 3'd2, 3'd1};
            sb.push_back(32'h1111); sb.push_back(32'h2222);
            sb.push_back(32'hBEEF); sb.push_back(32'h4444);
            #2;
            for (int p = 0; p < 4; p++) begin
                got_v = 32'(b2.rd_data[p*16 +: 16]); exp_v = sb.pop_front(); vectors++;
                if (got_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL wide_read step%0d port%0d got=%h exp=%h", step, p, got_v, exp_v);
                end
            end
        end
        @(negedge clk);
        b2.clr_req = 1'b1;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            b2.clr_req = 1'b0;
            #2;
            if (b2.clr_busy && !b2.clr_done) clr_n++;
            if (b2.clr_done) done_n++;
        end
        sb.push_back(32'd8); sb.push_back(32'd1);
        for (int i = 0; i < 2; i++) begin
            got_v = (i == 0) ? 32'(clr_n) : 32'(done_n);
            exp_v = sb.pop_front(); vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL wide_clear idx%0d got=%0d exp=%0d", i, got_v, exp_v);
            end
        end
        for (int a = 0; a < 8; a += 4) begin
            @(negedge clk);
            b2.rd_addr = {3'(a + 3), 3'(a + 2), 3'(a + 1), 3'(a)};
            for (int p = 0; p < 4; p++) sb.push_back(32'd0);
            #2;
            for (int p = 0; p < 4; p++) begin
                got_v = 32'(b2.rd_data[p*16 +: 16]); exp_v = sb.pop_front(); vectors++;
                if (got_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL wide_final a=%0d port%0d got=%h exp=%h", a + p, p, got_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_reset_mid_clear();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
